onehot_event_gen: RTL and testbench

//  - Upstream stage of the 4-to-2 encoder: turns four raw, asynchronous push-button lines into a

---
 rtl/onehot_event_gen.sv | 176 +++++++++++++++++
 tb/tb_onehot_event_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_event_gen.sv
// onehot_event_gen: four raw push-button lines -> synchronise, debounce,
// rising-edge detect -> pending bits -> highest-index arbiter -> event FIFO.
// Presents one one-hot press event at a time on d_out with a valid/ready handshake.
// Optional build macro ONEHOT_EVT_DROP_OLDEST_EN: when defined, a push into a
// full FIFO with no pop overwrites the oldest entry (newest events retained);
// when undefined, the push is withheld and the event waits in pending.
module onehot_event_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned AW              = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  output logic [3:0] d_out,
  output logic       d_valid,
  input  logic       d_ready,
  output logic       fifo_full,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int unsigned     NL        = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]      DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  // Synchroniser and debounce state
  logic [NL-1:0]    s1;
  logic [NL-1:0]    s2;
  logic [NL-1:0]    stable;
  logic [CNT_W-1:0] cnt [NL];

  // Event bookkeeping
  logic [NL-1:0]    rise;
  logic [NL-1:0]    pending;
  logic [NL-1:0]    pending_next;
  logic [NL-1:0]    clr;
  logic [1:0]       sel;
  logic [3:0]       push_word;
  logic             has_pend;
  logic             push;
  logic             pop;
  logic             drop;
  logic             merge_loss;
  logic             full;

  // FIFO storage
  logic [3:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;

  // Two-flop synchroniser per button line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debounce: accept a level change after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable <= '0;
      for (int unsigned i = 0; i < NL; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NL; i++) begin
        if (s2[i] != stable[i]) begin
          if (cnt[i] == CNT_MAX) begin
            stable[i] <= s2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Press detect: the stable level is about to go 0->1 on this edge
  always_comb begin
    rise = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      rise[i] = s2[i] && !stable[i] && (cnt[i] == CNT_MAX);
    end
  end

  // Arbiter: highest pending index wins; decide push/pop/drop for this edge
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      if (pending[i]) begin
        sel = 2'(i);
      end
    end
    has_pend  = |pending;
    full      = (count == DEPTH_CNT);
    pop       = d_valid && d_ready;
`ifdef ONEHOT_EVT_DROP_OLDEST_EN
    push      = has_pend;
    drop      = has_pend && full && !pop;
`else
    push      = has_pend && (!full || pop);
    drop      = 1'b0;
`endif
    push_word = 4'b0001 << sel;
    clr       = push ? push_word : '0;
    // A press landing on the line being cleared survives: it re-sets pending, no loss
    merge_loss   = |(rise & pending & ~clr);
    pending_next = (pending & ~clr) | rise;
  end

  // Pending press register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // FIFO pointers and occupancy; a drop advances both pointers and keeps count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop || drop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (push && !pop && !drop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // Sticky overflow: a loss on this edge beats a clear request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (merge_loss || drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Outputs decoded from registered FIFO state only
  always_comb begin
    d_valid   = (count != '0);
    fifo_full = (count == DEPTH_CNT);
    d_out     = d_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_onehot_event_gen.sv
// Testbench for onehot_event_gen: reference model compared every cycle,
// table of vectors, directed multi-cycle sequences and a randomized run.
module tb_onehot_event_gen;

  localparam int D     = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'hF;
  logic       d_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] d_out;
  logic       d_valid;
  logic       fifo_full;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  onehot_event_gen #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(5),
    .FIFO_DEPTH(DEPTH),
    .AW(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .d_out(d_out),
    .d_valid(d_valid),
    .d_ready(d_ready),
    .fifo_full(fifo_full),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: synced view of btn, window of the last D synced samples
  // per line, accepted level, pending presses and an event queue of line indices.
  logic [3:0]   m_p1 = '0;
  logic [3:0]   m_p2 = '0;
  logic [3:0]   m_level = '0;
  logic [3:0]   m_pend = '0;
  logic [D-1:0] m_win [4];
  int           m_fill [4];
  int           m_q [$];
  logic         m_ov = 1'b0;

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    logic       clr;
    int         cycles;
    logic [3:0] e_dout;
    logic       e_valid;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t       tbl [12];
  logic [3:0] exp_seq [5];
  int         hold [4];
  logic [3:0] lvl;
  int         phase;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0] synced;
    logic [3:0] clr;
    logic [3:0] rise;
    int         hi;
    logic       push;
    logic       drop;
    logic       pop;
    logic       loss;
    if (!rst_n) begin
      m_p1 = '0; m_p2 = '0; m_level = '0; m_pend = '0; m_ov = 1'b0;
      m_q.delete();
      for (int i = 0; i < 4; i++) begin
        m_win[i] = '0;
        m_fill[i] = 0;
      end
      return;
    end
    synced = m_p2;
    m_p2 = m_p1;
    m_p1 = btn;
    pop  = (m_q.size() != 0) && d_ready;
    push = 1'b0; drop = 1'b0; clr = '0; hi = 0;
    if (m_pend != 0) begin
      for (int i = 0; i < 4; i++) if (m_pend[i]) hi = i;
`ifdef ONEHOT_EVT_DROP_OLDEST_EN
      push = 1'b1;
      drop = (m_q.size() == DEPTH) && !pop;
`else
      push = (m_q.size() < DEPTH) || pop;
`endif
      if (push) clr[hi] = 1'b1;
    end
    rise = '0;
    for (int i = 0; i < 4; i++) begin
      m_win[i] = {m_win[i][D-2:0], synced[i]};
      if (m_fill[i] < D) m_fill[i]++;
      if (m_fill[i] == D && m_win[i] == {D{~m_level[i]}}) begin
        m_level[i] = synced[i];
        rise[i] = synced[i];
      end
    end
    loss = ((rise & m_pend & ~clr) != 0) || drop;
    m_pend = (m_pend & ~clr) | rise;
    if (pop) void'(m_q.pop_front());
    if (drop) void'(m_q.pop_front());
    if (push) m_q.push_back(hi);
    if (loss) m_ov = 1'b1;
    else if (ovf_clr) m_ov = 1'b0;
  endtask

  task automatic compare_model();
    logic [3:0] e;
    e = (m_q.size() != 0) ? (4'b0001 << m_q[0]) : 4'b0000;
    chk("model_d_out", d_out, e);
    chk("model_d_valid", {3'b0, d_valid}, {3'b0, (m_q.size() != 0)});
    chk("model_fifo_full", {3'b0, fifo_full}, {3'b0, (m_q.size() == DEPTH)});
    chk("model_overflow", {3'b0, overflow}, {3'b0, m_ov});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn = '0; d_ready = 1'b0; ovf_clr = 1'b0;
    run(3);
    rst_n = 1'b1;
  endtask

  task automatic press(input int line);
    btn = 4'b0001 << line;
    run(25);
    btn = '0;
    run(25);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 25, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b0, 1'b0, 25, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{4'b0010, 1'b0, 1'b0, 25, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{4'b0000, 1'b0, 1'b0, 25, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{4'b0100, 1'b0, 1'b0, 25, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 25, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{4'b1000, 1'b0, 1'b0, 25, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{4'b0000, 1'b0, 1'b0, 25, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0, 1,  4'b0010, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{4'b0000, 1'b1, 1'b0, 1,  4'b0100, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 2,  4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'b0000, 1'b0, 1'b1, 3,  4'b0000, 1'b0, 1'b0, 1'b0};

    // Reset held for 3 cycles with all buttons high
    rst_n = 1'b0; btn = 4'hF;
    run(3);
    rst_n = 1'b1;
    step();
    chk("reset_d_out", d_out, 4'b0000);
    chk("reset_d_valid", {3'b0, d_valid}, 4'b0000);
    chk("reset_fifo_full", {3'b0, fifo_full}, 4'b0000);
    chk("reset_overflow", {3'b0, overflow}, 4'b0000);
    btn = '0;
    run(10);

    // Vector table
    for (int k = 0; k < 12; k++) begin
      btn = tbl[k].btn; d_ready = tbl[k].rdy; ovf_clr = tbl[k].clr;
      run(tbl[k].cycles);
      chk($sformatf("vec%0d_d_out", k), d_out, tbl[k].e_dout);
      chk($sformatf("vec%0d_d_valid", k), {3'b0, d_valid}, {3'b0, tbl[k].e_valid});
      chk($sformatf("vec%0d_fifo_full", k), {3'b0, fifo_full}, {3'b0, tbl[k].e_full});
      chk($sformatf("vec%0d_overflow", k), {3'b0, overflow}, {3'b0, tbl[k].e_ovf});
    end
    ovf_clr = 1'b0;

    // Glitch reject, then a real press with the documented latency
    do_reset();
    btn = 4'b0010;
    run(10);
    btn = '0;
    run(30);
    chk("glitch_d_valid", {3'b0, d_valid}, 4'b0000);
    btn = 4'b0010;
    run(18);
    chk("latency_edge18_d_valid", {3'b0, d_valid}, 4'b0000);
    run(1);
    chk("latency_edge19_d_valid", {3'b0, d_valid}, 4'b0001);
    chk("latency_edge19_d_out", d_out, 4'b0010);

    // Simultaneous presses: highest index first
    do_reset();
    btn = 4'b0101; d_ready = 1'b1;
    run(18);
    chk("simul_edge18_d_valid", {3'b0, d_valid}, 4'b0000);
    run(1);
    chk("simul_first_d_out", d_out, 4'b0100);
    run(1);
    chk("simul_second_d_out", d_out, 4'b0001);
    run(1);
    chk("simul_drained_d_valid", {3'b0, d_valid}, 4'b0000);
    btn = '0;
    run(25);

`ifdef ONEHOT_EVT_DROP_OLDEST_EN
    // Full of line-0 events; a line-3 press overwrites the oldest
    do_reset();
    for (int i = 0; i < 4; i++) press(0);
    chk("drop_full", {3'b0, fifo_full}, 4'b0001);
    chk("drop_pre_overflow", {3'b0, overflow}, 4'b0000);
    press(3);
    chk("drop_overflow", {3'b0, overflow}, 4'b0001);
    chk("drop_still_full", {3'b0, fifo_full}, 4'b0001);
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b1000;
    d_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drop_order%0d", k), d_out, exp_seq[k]);
      step();
    end
    chk("drop_drained_d_valid", {3'b0, d_valid}, 4'b0000);
`else
    // Backpressure: four presses fill the FIFO, a fifth waits in pending
    do_reset();
    for (int i = 0; i < 4; i++) press(i);
    chk("bp_full", {3'b0, fifo_full}, 4'b0001);
    chk("bp_overflow", {3'b0, overflow}, 4'b0000);
    press(2);
    chk("bp_fifth_full", {3'b0, fifo_full}, 4'b0001);
    chk("bp_fifth_overflow", {3'b0, overflow}, 4'b0000);
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0100;
    d_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_order%0d", k), d_out, exp_seq[k]);
      step();
    end
    chk("bp_drained_d_valid", {3'b0, d_valid}, 4'b0000);

    // Loss through pending merge, then clear
    d_ready = 1'b0;
    for (int i = 0; i < 4; i++) press(i);
    press(2);
    chk("loss_first_overflow", {3'b0, overflow}, 4'b0000);
    press(2);
    chk("loss_overflow", {3'b0, overflow}, 4'b0001);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("loss_cleared_overflow", {3'b0, overflow}, 4'b0000);
    chk("loss_still_full", {3'b0, fifo_full}, 4'b0001);
`endif

    // Randomized run against the model
    do_reset();
    lvl = '0;
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 40);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          lvl[i] = ~lvl[i];
          hold[i] = $urandom_range(1, 40);
        end else begin
          hold[i]--;
        end
      end
      btn = lvl;
      phase = (cyc / 400) % 3;
      if (phase == 0) d_ready = ($urandom_range(0, 3) != 0);
      else if (phase == 1) d_ready = ($urandom_range(0, 7) == 0);
      else d_ready = 1'b0;
      ovf_clr = ($urandom_range(0, 39) == 0);
      rst_n = !(cyc >= 2500 && cyc < 2502);
      step();
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
